hist_eq_map: RTL

HIST_EQ_MAP -- requirements
Module: hist_eq_map

---
 rtl/hist_eq_map_if.sv | 40 ++++
 rtl/hist_eq_map.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hist_eq_map_if.sv
// Bundle carrying the cumulative-histogram stream, the source video and the
// equalized video. master drives stream + source video; slave is the mapper.
interface hist_eq_map_if;
    logic [7:0]  pixel_level;
    logic [19:0] pixel_level_acc_num;
    logic        pixel_level_valid;
    logic        img_vsync;
    logic        img_href;
    logic [7:0]  img_gray;
    logic        post_img_vsync;
    logic        post_img_href;
    logic [7:0]  post_img_gray;
    logic        lut_ready;

    modport master (
        output pixel_level,
        output pixel_level_acc_num,
        output pixel_level_valid,
        output img_vsync,
        output img_href,
        output img_gray,
        input  post_img_vsync,
        input  post_img_href,
        input  post_img_gray,
        input  lut_ready
    );

    modport slave (
        input  pixel_level,
        input  pixel_level_acc_num,
        input  pixel_level_valid,
        input  img_vsync,
        input  img_href,
        input  img_gray,
        output post_img_vsync,
        output post_img_href,
        output post_img_gray,
        output lut_ready
    );
endinterface

// File: rtl/hist_eq_map.sv
// Histogram-equalization mapper: builds a 256-entry gray-level LUT from a
// cumulative-histogram stream into a shadow bank and swaps it in on a vsync
// rise, while remapping the live video through the active bank.
// Ports: clk, rst (sync, active high), bus (hist_eq_map_if.slave):
//   pixel_level/pixel_level_acc_num/pixel_level_valid - table stream in
//   img_vsync/img_href/img_gray - source video in
//   post_img_vsync/post_img_href/post_img_gray - equalized video, 2-cycle delay
//   lut_ready - a complete table has been committed at least once
// Option: define HIST_EQ_MAP_ROUND_EN to round instead of truncate entries.
module hist_eq_map #(
    parameter int unsigned IMG_TOTAL = 307200
) (
    input logic         clk,
    input logic         rst,
    hist_eq_map_if.slave bus
);

    localparam logic [31:0] SCALE =
        32'((64'd255 << 24) / 64'(IMG_TOTAL));

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [7:0]  exp_lvl;
    logic        got_last;
    logic        bank;
    logic        ready;
    logic        vs_d;
    logic        vs_rise;
    logic        start;
    logic        accept;
    logic        abort;

    logic        v1;
    logic [7:0]  l1;
    logic [51:0] prod;
    logic        v2;
    logic [7:0]  a2;
    logic [7:0]  d2;
    logic [7:0]  lut_val;

    logic        vs1;
    logic        hs1;
    logic [7:0]  addr1;
    logic        post_vs;
    logic        post_hs;
    logic [7:0]  post_gray;

    // Bank b occupies entries {b, level}; shadow is always ~bank.
    logic [7:0]  lut [512];

    assign vs_rise = bus.img_vsync & ~vs_d;
    assign start   = bus.pixel_level_valid && (bus.pixel_level == 8'd0);

    // Once level 255 is taken the stream may end; only the pipeline
    // drain (level-255 write) is awaited after that.
    always_comb begin
        accept = 1'b0;
        abort  = 1'b0;
        unique case (state)
            IDLE: accept = start;
            LOAD: begin
                if (!got_last) begin
                    if (bus.pixel_level_valid &&
                        bus.pixel_level == exp_lvl)
                        accept = 1'b1;
                    else
                        abort = 1'b1;
                end
            end
            DONE: accept = start;
            default: accept = 1'b0;
        endcase
    end

`ifdef HIST_EQ_MAP_ROUND_EN
    logic [52:0] rsum;
    logic        unused_bits;
    assign rsum        = {1'b0, prod} + (53'd1 << 23);
    assign unused_bits = ^rsum[23:0];
    assign lut_val     = (|rsum[52:32]) ? 8'hFF : rsum[31:24];
`else
    logic        unused_bits;
    assign unused_bits = ^prod[23:0];
    assign lut_val     = (|prod[51:32]) ? 8'hFF : prod[31:24];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            exp_lvl  <= 8'd0;
            got_last <= 1'b0;
            bank     <= 1'b0;
            ready    <= 1'b0;
            vs_d     <= 1'b0;
            v1       <= 1'b0;
            l1       <= 8'd0;
            prod     <= 52'd0;
            v2       <= 1'b0;
            a2       <= 8'd0;
            d2       <= 8'd0;
        end else begin
            vs_d <= bus.img_vsync;
            v1   <= accept;
            l1   <= bus.pixel_level;
            prod <= 52'(bus.pixel_level_acc_num) * 52'(SCALE);
            v2   <= v1;
            a2   <= l1;
            d2   <= lut_val;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        exp_lvl  <= 8'd1;
                        got_last <= 1'b0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (got_last) begin
                        if (v2 && a2 == 8'hFF)
                            state <= DONE;
                    end else begin
                        exp_lvl <= exp_lvl + 8'd1;
                        if (exp_lvl == 8'hFF)
                            got_last <= 1'b1;
                    end
                end
                DONE: begin
                    // A commit flips the shadow, so a level-0 entry in the
                    // same cycle starts the next table in the new shadow.
                    if (vs_rise) begin
                        bank  <= ~bank;
                        ready <= 1'b1;
                    end
                    if (start) begin
                        state    <= LOAD;
                        exp_lvl  <= 8'd1;
                        got_last <= 1'b0;
                    end else if (vs_rise) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (v2)
            lut[{~bank, a2}] <= d2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs1       <= 1'b0;
            hs1       <= 1'b0;
            addr1     <= 8'd0;
            post_vs   <= 1'b0;
            post_hs   <= 1'b0;
            post_gray <= 8'd0;
        end else begin
            vs1     <= bus.img_vsync;
            hs1     <= bus.img_href;
            addr1   <= bus.img_gray;
            post_vs <= vs1;
            post_hs <= hs1;
            if (!hs1)
                post_gray <= 8'd0;
            else if (ready)
                post_gray <= lut[{bank, addr1}];
            else
                post_gray <= addr1;
        end
    end

    assign bus.post_img_vsync = post_vs;
    assign bus.post_img_href  = post_hs;
    assign bus.post_img_gray  = post_gray;
    assign bus.lut_ready      = ready;

endmodule
